chime_sequencer: RTL and testbench

//   Generates the two-tone "ding-dong" stimulus for the doorbell sound mux directly downstream.
//   A button press starts a one-shot sequence:

---
 rtl/chime_pkg.sv | 24 ++
 rtl/chime_tone_gen.sv | 32 +++
 rtl/chime_sequencer.sv | 93 +++++++++
 tb/tb_chime_sequencer.sv | 137 +++++++++++++
 4 files changed

// File: rtl/chime_pkg.sv
// Shared types and default timing for the doorbell chime sequencer.
// Lengths and half-periods are in clk cycles.
package chime_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DING,
    GAP,
    DONG
  } chime_state_t;

  localparam int DEF_DIV_A    = 2500;
  localparam int DEF_DIV_B    = 3125;
  localparam int DEF_DING_LEN = 1000;
  localparam int DEF_GAP_LEN  = 100;
  localparam int DEF_DONG_LEN = 1500;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/chime_tone_gen.sv
// Half-period square-wave generator; en low holds counter and tone at 0.
// The tone register is the output, so the first high level appears DIV cycles after en rises.
module tone_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tone
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_tone;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      r_cnt  <= '0;
      r_tone <= 1'b0;
    end else if (r_cnt == LAST) begin
      r_cnt  <= '0;
      r_tone <= ~r_tone;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  assign tone = r_tone;

endmodule

// File: rtl/chime_sequencer.sv
// One-shot ding / gap / dong sequencer feeding the doorbell sound mux.
// Edge detect, phase FSM and phase counter live here; tones come from tone_gen.
module chime_sequencer
  import chime_pkg::*;
#(
  parameter int DIV_A    = DEF_DIV_A,
  parameter int DIV_B    = DEF_DIV_B,
  parameter int DING_LEN = DEF_DING_LEN,
  parameter int GAP_LEN  = DEF_GAP_LEN,
  parameter int DONG_LEN = DEF_DONG_LEN
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic tone_a,
  output logic tone_b,
  output logic sel,
  output logic busy
);

  localparam int MAXL = max3(DING_LEN, GAP_LEN, DONG_LEN);
  localparam int PCW  = (MAXL > 1) ? $clog2(MAXL) : 1;

  localparam logic [PCW-1:0] L_DING = PCW'(DING_LEN - 1);
  localparam logic [PCW-1:0] L_GAP  = PCW'(GAP_LEN - 1);
  localparam logic [PCW-1:0] L_DONG = PCW'(DONG_LEN - 1);

  chime_state_t   r_state;
  chime_state_t   w_state_nxt;
  logic [PCW-1:0] r_cnt;
  logic [PCW-1:0] w_cnt_nxt;
  logic           r_button_q;
  logic           r_sel;
  logic           r_busy;
  logic           w_rise;
  logic           w_en_a;
  logic           w_en_b;

  assign w_rise = button & ~r_button_q;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    unique case (r_state)
      IDLE: if (w_rise) w_state_nxt = DING;
      DING: if (r_cnt == L_DING)
              w_state_nxt = (GAP_LEN > 0) ? GAP : DONG;
      GAP:  if (r_cnt == L_GAP) w_state_nxt = DONG;
      DONG: if (r_cnt == L_DONG) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (w_state_nxt != r_state || w_state_nxt == IDLE)
      w_cnt_nxt = '0;
  end

  // button_q keeps sampling during reset so a press held across reset is not an edge
  always_ff @(posedge clk) begin
    r_button_q <= button;
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sel   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sel   <= (w_state_nxt == DONG);
      r_busy  <= (w_state_nxt != IDLE);
    end
  end

  // Dropping en on the exit edge guarantees a tone is 0 the cycle after its phase
  assign w_en_a = (r_state == DING) && (w_state_nxt == DING);
  assign w_en_b = (r_state == DONG) && (w_state_nxt == DONG);

  tone_gen #(.DIV(DIV_A)) u_tone_a (
    .clk  (clk),
    .rst  (rst),
    .en   (w_en_a),
    .tone (tone_a)
  );

  tone_gen #(.DIV(DIV_B)) u_tone_b (
    .clk  (clk),
    .rst  (rst),
    .en   (w_en_b),
    .tone (tone_b)
  );

  assign sel  = r_sel;
  assign busy = r_busy;

endmodule

// File: tb/tb_chime_sequencer.sv
// Directed bench for chime_sequencer with short tones and phases.
// A second instance is built without a gap.
module tb_chime_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic btn1;
  logic btn2;
  logic a1, b1, s1, y1;
  logic a2, b2, s2, y2;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] a_pat = 8'b1100_1100;
  logic [5:0] b_pat = 6'b111000;

  always #5 clk = ~clk;

  chime_sequencer #(
    .DIV_A(2), .DIV_B(3), .DING_LEN(8), .GAP_LEN(2), .DONG_LEN(6)
  ) dut (
    .clk(clk), .rst(rst), .button(btn1),
    .tone_a(a1), .tone_b(b1), .sel(s1), .busy(y1)
  );

  chime_sequencer #(
    .DIV_A(2), .DIV_B(3), .DING_LEN(8), .GAP_LEN(0), .DONG_LEN(6)
  ) dut_ng (
    .clk(clk), .rst(rst), .button(btn2),
    .tone_a(a2), .tone_b(b2), .sel(s2), .busy(y2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int c,
                     input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d]: observed {a,b,sel,busy}=%b expected %b",
             tag, c, obs, exp);
    end
  endtask

  function automatic logic [3:0] obs_of(input int gap);
    return (gap == 0) ? {a2, b2, s2, y2} : {a1, b1, s1, y1};
  endfunction

  // mode 0: single press, 1: retrigger pulses, 2: button held
  task automatic run_seq(input string tag, input int gap,
                         input int mode, input int stop_at);
    int len;
    logic [3:0] exp;
    logic nb;
    len = 8 + gap + 6;
    for (int c = 0; c < len; c++) begin
      tick();
      if (c < 8)
        exp = {a_pat[c], 1'b0, 1'b0, 1'b1};
      else if (c < 8 + gap)
        exp = 4'b0001;
      else
        exp = {1'b0, b_pat[c-8-gap], 1'b1, 1'b1};
      chk(tag, c, obs_of(gap), exp);
      if (c == stop_at) return;
      nb = (mode == 2) || (mode == 1 && (c == 3 || c == 12));
      if (gap == 0) btn2 = nb;
      else btn1 = nb;
    end
    tick();
    chk({tag, "_end"}, len, obs_of(gap), 4'b0000);
  endtask

  initial begin
    rst  = 1'b1;
    btn1 = 1'b1;
    btn2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset", i, {a1, b1, s1, y1}, 4'b0000);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("held_after_rst", i, {a1, b1, s1, y1}, 4'b0000);
    end
    btn1 = 1'b0;
    tick();
    chk("idle", 0, {a1, b1, s1, y1}, 4'b0000);

    btn1 = 1'b1;
    run_seq("press", 2, 0, -1);

    tick();
    btn1 = 1'b1;
    run_seq("retrig", 2, 1, -1);

    tick();
    chk("nogap_idle", 0, {a2, b2, s2, y2}, 4'b0000);
    btn2 = 1'b1;
    run_seq("nogap", 0, 0, -1);

    tick();
    btn1 = 1'b1;
    run_seq("mid", 2, 0, 13);
    rst = 1'b1;
    tick();
    chk("rst_mid", 0, {a1, b1, s1, y1}, 4'b0000);
    rst = 1'b0;
    tick();
    chk("rst_mid", 1, {a1, b1, s1, y1}, 4'b0000);
    btn1 = 1'b1;
    run_seq("replay", 2, 0, -1);

    tick();
    btn1 = 1'b1;
    run_seq("hold", 2, 2, -1);
    for (int i = 0; i < 23; i++) begin
      tick();
      chk("held", i, {a1, b1, s1, y1}, 4'b0000);
    end
    btn1 = 1'b0;
    tick();
    chk("release", 0, {a1, b1, s1, y1}, 4'b0000);
    btn1 = 1'b1;
    run_seq("again", 2, 0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
